awg_cmd_parser: RTL and testbench

Framed command parser for the AWG. It consumes the byte stream from the UART receiver (`data_in`/`data_valid`), validates each framed command (sync, opcode, payload, XOR checksum, range, inter-byte timeout) and holds the waveform configuration registers that feed the waveform generator. A register changes only when a complete, valid frame has been received, so a corrupted frame never changes the waveform.

---
 rtl/awg_cmd_parser.sv | 138 +++++++++++++
 tb/tb_awg_cmd_parser.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/awg_cmd_parser.sv
// awg_cmd_parser: framed UART command parser holding the AWG waveform configuration registers.
module awg_cmd_parser #(
   parameter int          TIMEOUT_CYCLES = 100000,
   parameter logic [1:0]  DEF_TYPE       = 2'd0,
   parameter logic [16:0] DEF_FREQ       = 17'd1000,
   parameter logic [9:0]  DEF_AMP        = 10'd512,
   parameter logic [9:0]  DEF_OFFSET     = 10'd512
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  data_in,
   input  logic        data_valid,
   output logic [1:0]  waveform_type,
   output logic [16:0] frequency,
   output logic [9:0]  amplitude,
   output logic [9:0]  dc_offset,
   output logic        cfg_update,
   output logic        frame_err,
   output logic [1:0]  err_code
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   typedef enum logic [1:0] {S_IDLE, S_CMD, S_PAYLOAD, S_CHECK} state_t;
   state_t        state_q, state_d;
   logic [2:0]    cmd_q, cmd_d;
   logic [1:0]    len_q, len_d;
   logic [23:0]   shift_q, shift_d;
   logic [7:0]    xor_q, xor_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    type_q, type_d, code_q, code_d;
   logic [16:0]   freq_q, freq_d;
   logic [9:0]    amp_q, amp_d, off_q, off_d;
   logic          upd_q, upd_d, err_q, err_d;
   logic          timeout, range_ok;

   assign timeout  = (state_q != S_IDLE) && !data_valid && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
   assign range_ok = (cmd_q == 3'd1) ? (shift_q[7:2] == '0) :
                     (cmd_q == 3'd2) ? (shift_q[23:17] == '0) : (shift_q[15:10] == '0);

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      len_d   = len_q;
      shift_d = shift_q;
      xor_d   = xor_q;
      cnt_d   = (state_q == S_IDLE || data_valid) ? '0 : cnt_q + 1'b1;
      type_d  = type_q;
      freq_d  = freq_q;
      amp_d   = amp_q;
      off_d   = off_q;
      code_d  = code_q;
      upd_d   = 1'b0;
      err_d   = 1'b0;
      if (data_valid) begin
         case (state_q)
            S_IDLE: state_d = (data_in == 8'hA5) ? S_CMD : S_IDLE;
            S_CMD: begin
               if (data_in != 8'd0 && data_in < 8'd5) begin
                  cmd_d   = data_in[2:0];
                  len_d   = (data_in == 8'd1) ? 2'd1 : (data_in == 8'd2) ? 2'd3 : 2'd2;
                  xor_d   = data_in;
                  shift_d = '0;
                  state_d = S_PAYLOAD;
               end else begin
                  err_d   = 1'b1;
                  code_d  = 2'd1;
                  state_d = S_IDLE;
               end
            end
            S_PAYLOAD: begin
               shift_d = {shift_q[15:0], data_in};
               xor_d   = xor_q ^ data_in;
               len_d   = len_q - 2'd1;
               state_d = (len_q == 2'd1) ? S_CHECK : S_PAYLOAD;
            end
            default: begin
               state_d = S_IDLE;
               if (data_in != xor_q || !range_ok) begin
                  err_d  = 1'b1;
                  code_d = (data_in != xor_q) ? 2'd2 : 2'd3;
               end else begin
                  upd_d  = 1'b1;
                  type_d = (cmd_q == 3'd1) ? shift_q[1:0]  : type_q;
                  freq_d = (cmd_q == 3'd2) ? shift_q[16:0] : freq_q;
                  amp_d  = (cmd_q == 3'd3) ? shift_q[9:0]  : amp_q;
                  off_d  = (cmd_q == 3'd4) ? shift_q[9:0]  : off_q;
               end
            end
         endcase
      end else if (timeout) begin
         state_d = S_IDLE;
         err_d   = 1'b1;
         code_d  = 2'd0;
         shift_d = '0;
         xor_d   = '0;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cmd_q   <= '0;
         len_q   <= '0;
         shift_q <= '0;
         xor_q   <= '0;
         cnt_q   <= '0;
         type_q  <= DEF_TYPE;
         freq_q  <= DEF_FREQ;
         amp_q   <= DEF_AMP;
         off_q   <= DEF_OFFSET;
         code_q  <= '0;
         upd_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         len_q   <= len_d;
         shift_q <= shift_d;
         xor_q   <= xor_d;
         cnt_q   <= cnt_d;
         type_q  <= type_d;
         freq_q  <= freq_d;
         amp_q   <= amp_d;
         off_q   <= off_d;
         code_q  <= code_d;
         upd_q   <= upd_d;
         err_q   <= err_d;
      end
   end

   assign waveform_type = type_q;
   assign frequency     = freq_q;
   assign amplitude     = amp_q;
   assign dc_offset     = off_q;
   assign cfg_update    = upd_q;
   assign frame_err     = err_q;
   assign err_code      = code_q;
endmodule

// File: tb/tb_awg_cmd_parser.sv
// tb_awg_cmd_parser: directed vector table, corner sequences and random frames against a frame-level model.
module tb_awg_cmd_parser;
   localparam int T = 20;
   logic        clk = 1'b0, rst_n = 1'b0, data_valid = 1'b0;
   logic [7:0]  data_in = 8'h00;
   logic [1:0]  waveform_type, err_code;
   logic [16:0] frequency;
   logic [9:0]  amplitude, dc_offset;
   logic        cfg_update, frame_err;
   int          tests = 0, fails = 0;

   awg_cmd_parser #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
      .waveform_type(waveform_type), .frequency(frequency), .amplitude(amplitude),
      .dc_offset(dc_offset), .cfg_update(cfg_update), .frame_err(frame_err), .err_code(err_code)
   );

   always #5 clk = ~clk;

   // Model: collects the bytes of the current frame and judges it once complete.
   int        m_type, m_freq, m_amp, m_off, m_upd, m_err, m_code, idle;
   logic [7:0] frm[$];
   logic [7:0] tx[$];

   function automatic int plen(input logic [7:0] op);
      return op == 8'd1 ? 1 : op == 8'd2 ? 3 : 2;
   endfunction

   task automatic model_reset();
      m_type = 0; m_freq = 1000; m_amp = 512; m_off = 512;
      m_upd = 0; m_err = 0; m_code = 0; idle = 0;
      frm.delete();
   endtask

   task automatic model_step(input logic v, input logic [7:0] b);
      int x, val, lim;
      m_upd = 0; m_err = 0;
      if (v) begin
         idle = 0;
         if (frm.size() == 0) begin
            if (b == 8'hA5) frm.push_back(b);
         end else begin
            frm.push_back(b);
            if (frm.size() == 2 && !(b >= 8'd1 && b <= 8'd4)) begin
               m_err = 1; m_code = 1; frm.delete();
            end else if (frm.size() == plen(frm[1]) + 3) begin
               x = 0; val = 0;
               for (int i = 1; i < frm.size() - 1; i++) x ^= int'(frm[i]);
               for (int i = 2; i < frm.size() - 1; i++) val = val * 256 + int'(frm[i]);
               lim = frm[1] == 8'd1 ? 4 : frm[1] == 8'd2 ? 131072 : 1024;
               if (int'(b) != x) begin m_err = 1; m_code = 2; end
               else if (val >= lim) begin m_err = 1; m_code = 3; end
               else begin
                  m_upd = 1;
                  case (frm[1])
                     8'd1: m_type = val;
                     8'd2: m_freq = val;
                     8'd3: m_amp = val;
                     default: m_off = val;
                  endcase
               end
               frm.delete();
            end
         end
      end else if (frm.size() > 0) begin
         idle++;
         if (idle == T) begin m_err = 1; m_code = 0; frm.delete(); idle = 0; end
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cmp_all();
      chk("type", 32'(waveform_type), m_type);
      chk("freq", 32'(frequency), m_freq);
      chk("amp", 32'(amplitude), m_amp);
      chk("offset", 32'(dc_offset), m_off);
      chk("cfg_update", 32'(cfg_update), m_upd);
      chk("frame_err", 32'(frame_err), m_err);
      chk("err_code", 32'(err_code), m_code);
   endtask

   task automatic step(input logic v, input logic [7:0] b);
      data_valid = v; data_in = b;
      @(posedge clk);
      model_step(v, b);
      @(negedge clk);
      data_valid = 1'b0;
      cmp_all();
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00);
   endtask

   task automatic send_tx();
      while (tx.size() > 0) step(1'b1, tx.pop_front());
   endtask

   function automatic int reg_sel(input int s);
      return s == 0 ? int'(waveform_type) : s == 1 ? int'(frequency) : s == 2 ? int'(amplitude) : int'(dc_offset);
   endfunction

   typedef struct {
      int          n;
      logic [47:0] b;
      logic        upd;
      logic        err;
      logic [1:0]  code;
      int          sel;
      int          val;
   } vec_t;
   vec_t tbl[8];

   initial begin
      logic [47:0] bb;
      int op, len, val, chk_b;
      tbl[0] = '{6, 48'hA5_02_00_27_10_35, 1'b1, 1'b0, 2'd0, 1, 10000};
      tbl[1] = '{5, 48'hA5_03_03_FF_FF_00, 1'b1, 1'b0, 2'd0, 2, 1023};
      tbl[2] = '{4, 48'hA5_01_02_03_00_00, 1'b1, 1'b0, 2'd0, 0, 2};
      tbl[3] = '{5, 48'hA5_03_01_00_00_00, 1'b0, 1'b1, 2'd2, 2, 1023};
      tbl[4] = '{5, 48'hA5_04_04_00_00_00, 1'b0, 1'b1, 2'd3, 3, 512};
      tbl[5] = '{2, 48'h11_22_00_00_00_00, 1'b0, 1'b0, 2'd3, 0, 2};
      tbl[6] = '{2, 48'hA5_07_00_00_00_00, 1'b0, 1'b1, 2'd1, 1, 10000};
      tbl[7] = '{5, 48'hA5_04_01_00_05_00, 1'b1, 1'b0, 2'd1, 3, 256};
      model_reset();
      repeat (3) @(negedge clk);
      cmp_all();
      rst_n = 1'b1;
      idle_n(2);

      foreach (tbl[k]) begin
         bb = tbl[k].b;
         for (int i = 0; i < tbl[k].n; i++) step(1'b1, bb[47 - 8*i -: 8]);
         chk($sformatf("vec%0d upd", k), 32'(cfg_update), 32'(tbl[k].upd));
         chk($sformatf("vec%0d err", k), 32'(frame_err), 32'(tbl[k].err));
         chk($sformatf("vec%0d code", k), 32'(err_code), 32'(tbl[k].code));
         chk($sformatf("vec%0d reg", k), reg_sel(tbl[k].sel), tbl[k].val);
      end

      // Timeout fires after exactly T idle cycles, then a clean frame commits.
      tx = '{8'hA5, 8'h02, 8'h00};
      send_tx();
      idle_n(T - 1);
      chk("to early", 32'(frame_err), 0);
      idle_n(1);
      chk("to err", 32'(frame_err), 1);
      chk("to code", 32'(err_code), 0);
      tx = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h05, 8'h07, 8'hA5, 8'h01, 8'h01, 8'h00};
      send_tx();
      chk("b2b type", 32'(waveform_type), 1);
      chk("b2b freq", 32'(frequency), 5);

      // A byte arriving on the cycle the timeout would expire wins.
      tx = '{8'hA5};
      send_tx();
      idle_n(T - 1);
      tx = '{8'h02, 8'h00, 8'h01, 8'h00, 8'h03};
      send_tx();
      chk("race freq", 32'(frequency), 256);
      chk("race upd", 32'(cfg_update), 1);

      // Mid-frame reset discards the partial frame and restores defaults.
      tx = '{8'hA5, 8'h02, 8'h00, 8'h27};
      send_tx();
      rst_n = 1'b0;
      model_reset();
      #1 cmp_all();
      @(negedge clk);
      rst_n = 1'b1;
      tx = '{8'h10, 8'h35};
      send_tx();
      chk("rst freq", 32'(frequency), 1000);
      chk("rst upd", 32'(cfg_update), 0);

      // Random traffic: mostly legal frames, with corruption, truncation, noise and gaps.
      for (int it = 0; it < 300; it++) begin
         if ($urandom_range(0, 9) == 0) begin
            tx.push_back(8'($urandom));
            if ($urandom_range(0, 3) == 0) tx.push_back(8'hA5);
         end else begin
            op = $urandom_range(0, 11) == 0 ? int'($urandom_range(5, 255)) : int'($urandom_range(1, 4));
            len = plen(8'(op));
            val = int'($urandom & 32'hFFFFFF);
            if ($urandom_range(0, 3) != 0)
               val &= op == 1 ? 3 : op == 2 ? 32'h1FFFF : 32'h3FF;
            tx.push_back(8'hA5);
            tx.push_back(8'(op));
            chk_b = op;
            for (int i = len - 1; i >= 0; i--) begin
               tx.push_back(8'(val >> (8*i)));
               chk_b ^= (val >> (8*i)) & 8'hFF;
            end
            if ($urandom_range(0, 7) == 0) chk_b ^= 1 << $urandom_range(0, 7);
            tx.push_back(8'(chk_b));
            if ($urandom_range(0, 9) == 0) void'(tx.pop_back());
         end
         while (tx.size() > 0) begin
            step(1'b1, tx.pop_front());
            if ($urandom_range(0, 19) == 0) idle_n($urandom_range(T - 2, T + 1));
            else if ($urandom_range(0, 5) == 0) idle_n(1);
         end
         idle_n($urandom_range(0, 2));
      end
      idle_n(T + 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
